// File: rtl/mul_pkg.sv
// Shared types for the iterative RV32M multiplier: op encodings and FSM states.
package mul_pkg;

  localparam int MUL_DEFAULT_WIDTH = 32;

  // Encodings follow funct3[1:0] of the RV32M multiply group
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_t;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic op_signed_a(input mul_op_t o);
    return (o == MULH) || (o == MULHSU);
  endfunction

  // rs2 is treated as signed only for MULH
  function automatic logic op_signed_b(input mul_op_t o);
    return (o == MULH);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder: 4-bit lookahead groups with the group carry rippled
// between groups. Operands are zero-padded up to a multiple of 4 bits.
module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] w_p;
  logic [PW-1:0] w_g;
  logic [PW:0]   w_c;

  // Per-bit propagate/generate, padded bits neither propagate nor generate
  always_comb begin
    w_p = '0;
    w_g = '0;
    w_p[WIDTH-1:0] = i_a ^ i_b;
    w_g[WIDTH-1:0] = i_a & i_b;
  end

  // Expanded lookahead equations inside each group, group carry-in from the previous group
  always_comb begin
    w_c = '0;
    w_c[0] = i_cin;
    for (int gi = 0; gi < NG; gi++) begin
      w_c[4*gi+1] = w_g[4*gi]
                  | (w_p[4*gi] & w_c[4*gi]);
      w_c[4*gi+2] = w_g[4*gi+1]
                  | (w_p[4*gi+1] & w_g[4*gi])
                  | (w_p[4*gi+1] & w_p[4*gi] & w_c[4*gi]);
      w_c[4*gi+3] = w_g[4*gi+2]
                  | (w_p[4*gi+2] & w_g[4*gi+1])
                  | (w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi])
                  | (w_p[4*gi+2] & w_p[4*gi+1] & w_p[4*gi] & w_c[4*gi]);
      w_c[4*gi+4] = w_g[4*gi+3]
                  | (w_p[4*gi+3] & w_g[4*gi+2])
                  | (w_p[4*gi+3] & w_p[4*gi+2] & w_g[4*gi+1])
                  | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi])
                  | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_p[4*gi] & w_c[4*gi]);
    end
  end

  assign o_sum  = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on acceptance, multiplied unsigned over
// WIDTH iterations through the shared CLA, then the 2W-bit product is negated
// in a single fix-up cycle when the operand signs differ.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  mul_state_t         r_state;
  mul_state_t         w_next_state;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_count;
  logic               r_neg;
  mul_op_t            r_op;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;

  mul_op_t            w_op;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_accept;
  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_fixed;

  // The most-negative value maps onto itself, which is the correct unsigned magnitude
  assign w_op     = mul_op_t'(op);
  assign w_sign_a = op_signed_a(w_op) & a[WIDTH-1];
  assign w_sign_b = op_signed_b(w_op) & b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (~a + ONE_W) : a;
  assign w_mag_b  = w_sign_b ? (~b + ONE_W) : b;

  assign in_ready  = (r_state == IDLE) & ~flush;
  assign w_accept  = in_valid & in_ready;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

  assign w_add_b = r_product[0] ? r_mcand : '0;
  assign w_fixed = r_neg ? (~r_product + ONE_2W) : r_product;

  cla_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_product[2*WIDTH-1:WIDTH]),
    .i_b    (w_add_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, flush overrides every other transition
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_next_state = CALC;
        CALC:    if (r_count == CNT_LAST) w_next_state = FIX;
        FIX:     w_next_state = DONE;
        DONE:    if (out_ready) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, shift-add iterations, sign fix-up and registered result
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_product   <= '0;
      r_mcand     <= '0;
      r_count     <= '0;
      r_neg       <= 1'b0;
      r_op        <= MUL;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_product <= {{WIDTH{1'b0}}, w_mag_b};
            r_mcand   <= w_mag_a;
            r_count   <= '0;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_op      <= w_op;
          end
        end
        CALC: begin
          if (!flush) begin
            r_product <= {w_cout, w_sum, r_product[WIDTH-1:1]};
            r_count   <= r_count + CNT_ONE;
          end
        end
        FIX: begin
          if (!flush) begin
            r_product   <= w_fixed;
            r_result    <= (r_op == MUL) ? w_fixed[WIDTH-1:0] : w_fixed[2*WIDTH-1:WIDTH];
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_result    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed + randomized bench for mul_unit with a result scoreboard.
module tb_mul_unit;
  import mul_pkg::*;

  localparam int W = 32;
  localparam int LATENCY = W + 1;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sbQueue[$];

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Reference product by sign/zero extension to 2W bits
  function automatic logic [W-1:0] refMul(input mul_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] ex;
    logic [2*W-1:0] ey;
    logic [2*W-1:0] p;
    ex = {{W{((o == MULH) || (o == MULHSU)) & x[W-1]}}, x};
    ey = {{W{(o == MULH) & y[W-1]}}, y};
    p  = ex * ey;
    return (o == MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input mul_op_t o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] exp, input bit expectResult);
    @(negedge clk);
    checkEq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
    checkEq({tag, "_busy"}, 64'(busy), 64'd1);
    if (expectResult) sbQueue.push_back(exp);
  endtask

  task automatic checkOutput(input string tag, input bit checkLatency);
    int n;
    logic [W-1:0] exp;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkEq({tag, "_valid_timeout"}, 64'(out_valid), 64'd1);
    if (checkLatency) checkEq({tag, "_latency"}, 64'(n), 64'(LATENCY));
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      exp = sbQueue.pop_front();
      checkEq({tag, "_result"}, 64'(result), 64'(exp));
    end
    if (out_ready) begin
      @(posedge clk);
      #1;
      checkEq({tag, "_retire_valid"}, 64'(out_valid), 64'd0);
      checkEq({tag, "_retire_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mul_op_t      ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    int           rises;

    n_rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    op = 2'b00;
    a = '0;
    b = '0;
    #12;
    checkEq("reset_in_ready", 64'(in_ready), 64'd1);
    checkEq("reset_busy", 64'(busy), 64'd0);
    checkEq("reset_out_valid", 64'(out_valid), 64'd0);
    checkEq("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    applyStimulus("mul_7x6", MUL, 32'd7, 32'd6, 32'h0000002A, 1'b1);
    checkOutput("mul_7x6", 1'b1);

    applyStimulus("mulh_m1x2", MULH, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b1);
    checkOutput("mulh_m1x2", 1'b1);
    applyStimulus("mul_m1x2", MUL, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b1);
    checkOutput("mul_m1x2", 1'b0);

    applyStimulus("mulhu_max", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    checkOutput("mulhu_max", 1'b0);
    applyStimulus("mul_max", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    checkOutput("mul_max", 1'b0);

    applyStimulus("mulhsu_max", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    checkOutput("mulhsu_max", 1'b0);
    applyStimulus("mulh_minneg", MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
    checkOutput("mulh_minneg", 1'b1);

    for (int i = 0; i < 8; i++) begin
      ro = mul_op_t'(i % 4);
      rx = $urandom;
      ry = $urandom;
      applyStimulus($sformatf("rand%0d_op%0d", i, i % 4), ro, rx, ry, refMul(ro, rx, ry), 1'b1);
      checkOutput($sformatf("rand%0d_op%0d", i, i % 4), 1'b0);
    end

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    applyStimulus("bp_3x5", MUL, 32'd3, 32'd5, 32'h0000000F, 1'b1);
    checkOutput("bp_3x5", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkEq($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
      checkEq($sformatf("bp_hold%0d_result", i), 64'(result), 64'h0000000F);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkEq("bp_retire_valid", 64'(out_valid), 64'd0);
    checkEq("bp_retire_ready", 64'(in_ready), 64'd1);

    // Flush in IDLE beats in_valid
    @(negedge clk);
    op = MUL;
    a = 32'd9;
    b = 32'd9;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    checkEq("flush_idle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    checkEq("flush_idle_busy", 64'(busy), 64'd0);

    // Flush during CALC iteration 10
    applyStimulus("flush_calc", MUL, 32'd9, 32'd9, 32'd81, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkEq("flush_calc_busy", 64'(busy), 64'd0);
    checkEq("flush_calc_valid", 64'(out_valid), 64'd0);
    rises = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) rises++;
    end
    checkEq("flush_calc_no_result", 64'(rises), 64'd0);
    applyStimulus("after_flush_2x2", MUL, 32'd2, 32'd2, 32'd4, 1'b1);
    checkOutput("after_flush_2x2", 1'b1);

    // Flush together with out_ready in DONE discards the result
    out_ready = 1'b0;
    applyStimulus("flush_done", MUL, 32'd5, 32'd5, 32'd25, 1'b1);
    checkOutput("flush_done", 1'b0);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkEq("flush_done_valid", 64'(out_valid), 64'd0);
    checkEq("flush_done_result", 64'(result), 64'd0);
    checkEq("flush_done_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-CALC
    applyStimulus("rst_calc", MUL, 32'h1234, 32'h10, 32'h12340, 1'b0);
    repeat (12) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checkEq("rst_calc_busy", 64'(busy), 64'd0);
    checkEq("rst_calc_valid", 64'(out_valid), 64'd0);
    checkEq("rst_calc_result", 64'(result), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus("after_rst_0x0", MUL, 32'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("after_rst_0x0", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
